// File: rtl/board_io_pkg.sv
// Shared types and constants for board input conditioning.
// State encoding keeps bit 1 equal to the accepted level.
package board_io_pkg;

    typedef enum logic [1:0] {
        IDLE_LO = 2'b00,
        WAIT_HI = 2'b01,
        IDLE_HI = 2'b11,
        WAIT_LO = 2'b10
    } state_t;

    localparam int DEFAULT_STABLE_CYCLES  = 1000000;
    localparam int FAST_SIM_STABLE_CYCLES = 16;

endpackage

// File: rtl/debounce_chan.sv
// One debounce channel: 2-flop synchronizer, stability FSM and counter,
// registered level plus one-cycle rise/fall pulses.
module debounce_chan
    import board_io_pkg::*;
#(
    parameter int STABLE = 8,
    parameter int CNT_W  = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic db,
    output logic rise,
    output logic fall
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE - 1);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    logic             s1;
    logic             s2;
    state_t           state;
    logic [CNT_W-1:0] cnt;

    // Bring the asynchronous pin into the clk domain.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    // Accept a level only after STABLE consecutive matching samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE_LO;
            cnt   <= '0;
            db    <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            unique case (state)
                IDLE_LO: begin
                    if (s2) begin
                        state <= WAIT_HI;
                        cnt   <= ONE;
                    end else begin
                        cnt <= '0;
                    end
                end
                WAIT_HI: begin
                    if (!s2) begin
                        state <= IDLE_LO;
                        cnt   <= '0;
                    end else if (cnt == LAST) begin
                        state <= IDLE_HI;
                        cnt   <= '0;
                        db    <= 1'b1;
                        rise  <= 1'b1;
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end
                IDLE_HI: begin
                    if (!s2) begin
                        state <= WAIT_LO;
                        cnt   <= ONE;
                    end else begin
                        cnt <= '0;
                    end
                end
                WAIT_LO: begin
                    if (s2) begin
                        state <= IDLE_HI;
                        cnt   <= '0;
                    end else if (cnt == LAST) begin
                        state <= IDLE_LO;
                        cnt   <= '0;
                        db    <= 1'b0;
                        fall  <= 1'b1;
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/board_input_debounce.sv
// Debounces N_IN board switches/buttons on the 100 MHz board clock.
// Define DEBOUNCE_FAST_SIM_EN to force a 16-cycle stable window.
module board_input_debounce
    import board_io_pkg::*;
#(
    parameter int N_IN          = 4,
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_IN-1:0] raw_in,
    output logic [N_IN-1:0] db_out,
    output logic [N_IN-1:0] rise_pls,
    output logic [N_IN-1:0] fall_pls
);

`ifdef DEBOUNCE_FAST_SIM_EN
    localparam int EFF_CYCLES = FAST_SIM_STABLE_CYCLES;
`else
    localparam int EFF_CYCLES = STABLE_CYCLES;
`endif

    localparam int CNT_W = $clog2(EFF_CYCLES + 1);

    // One fully independent channel per input pin.
    for (genvar i = 0; i < N_IN; i++) begin : g_chan
        debounce_chan #(
            .STABLE (EFF_CYCLES),
            .CNT_W  (CNT_W)
        ) u_chan (
            .clk  (clk),
            .rst  (rst),
            .raw  (raw_in[i]),
            .db   (db_out[i]),
            .rise (rise_pls[i]),
            .fall (fall_pls[i])
        );
    end

endmodule

// File: doc/board_input_debounce.md
Name: board_input_debounce

Overview:
- Conditions raw board switches and push-buttons before they reach the clock-divider and CPU control logic.
- Per channel: a 2-flop synchronizer, then a stability-counter FSM.
- Outputs per channel: a clean level, plus one-cycle rise and fall pulses.
- Feeds the clock-select switch input of the CPU clock divider, the CPU reset request, and manual single-step buttons.
- Runs entirely on the 100 MHz board clock.

Parameters:
- N_IN, 4: number of independent input channels.
- STABLE_CYCLES, 1000000: consecutive stable cycles required before a level change is accepted; 10 ms at 100 MHz; legal range 2 or more.
- CNT_W, $clog2(STABLE_CYCLES+1): per-channel counter width; derived, not overridden.

Ports:
- clk  input  1  system board clock, 100 MHz.
- rst  input  1  synchronous, active-high reset.
- raw_in  input  N_IN  asynchronous switch/button pins.
- db_out  output  N_IN  debounced level.
- rise_pls  output  N_IN  one-cycle pulse on accepted 0->1.
- fall_pls  output  N_IN  one-cycle pulse on accepted 1->0.

Behaviour:
- Reset is synchronous and active-high, on clk: all state changes only on posedge clk, including reset.
- While rst=1, per channel:
  - sync flops = 0, counter = 0, state = IDLE_LO.
  - db_out = 0, rise_pls = 0, fall_pls = 0.
- Synchronizer: s1 <= raw_in; s2 <= s1. Only s2 is used downstream.
- Per-channel FSM states: IDLE_LO, WAIT_HI, IDLE_HI, WAIT_LO.
- IDLE_LO:
  - s2=1 -> WAIT_HI, counter=1.
  - else stay, counter=0.
- WAIT_HI:
  - s2=0 (bounce) -> IDLE_LO, counter=0, no pulse.
  - s2=1 and counter=STABLE_CYCLES-1 -> IDLE_HI, db_out<=1, rise_pls<=1 for exactly one cycle.
  - else counter+1.
- IDLE_HI and WAIT_LO: mirror of the above with polarity inverted; the transition emits fall_pls.
- Latency: raw_in held stable from cycle T -> db_out and pulse registered at edge T+STABLE_CYCLES+2 (2 sync + STABLE_CYCLES count). Pulse and db_out change on the same edge.
- Counter never exceeds STABLE_CYCLES-1; no wrap-around possible. In IDLE states the counter is held at 0.
- Glitch shorter than STABLE_CYCLES sampled cycles -> no db_out change, no pulse.
- rise_pls and fall_pls are never both 1 on one channel in one cycle. No pulse is emitted in the cycle rst deasserts.
- Power-up with a switch already high: after rst release the channel follows normal latency, db_out rises and rise_pls fires once.
- rst asserted mid-WAIT: pending change is discarded. Channels are fully independent.

Optional Feature:
- Macro: DEBOUNCE_FAST_SIM_EN.
- Defined: effective stable count = 16 regardless of STABLE_CYCLES; CNT_W sized for 16. Used for simulation and board bring-up.
- Undefined: STABLE_CYCLES applies as parameterized.
- All other behaviour is identical in both builds.

Decomposition:
- Package board_io_pkg holds:
  - the 2-bit state enum: IDLE_LO=00, WAIT_HI=01, IDLE_HI=11, WAIT_LO=10.
  - DEFAULT_STABLE_CYCLES=1000000.
  - FAST_SIM_STABLE_CYCLES=16.
- Sub-module debounce_chan: single-bit synchronizer + FSM + counter + pulse regs.
- Top instantiates N_IN copies via generate.

Test Plan (STABLE_CYCLES=8, N_IN=4):
1. Reset: hold rst 3 cycles with raw_in=4'hF -> db_out, rise_pls and fall_pls all 0 throughout; after release db_out=4'hF exactly 10 cycles later, with rise_pls=4'hF for 1 cycle.
2. Clean press: raw_in[0] 0->1 held -> db_out[0]=1 after 10 cycles, rise_pls[0] high 1 cycle; release -> fall_pls[0] after 10 cycles.
3. Bounce: raw_in[1] toggles high 5 cycles / low 1 cycle repeatedly, then settles high -> db_out[1] rises exactly 10 cycles after the final settle; no intermediate pulses.
4. Short glitch: raw_in[2] high for 7 cycles then low -> db_out[2] stays 0, no pulses.
5. Reset mid-operation: rst asserted during WAIT_HI, 4 cycles into the count -> db_out=0; after release with input still high, full 10-cycle latency restarts.
6. Independence: raw_in[3] and raw_in[0] change on the same edge in opposite directions -> each channel's pulse fires on the same cycle, with correct polarity.
